// File: rtl/axis_sync_fifo.sv
// Single-clock AXI-Stream FIFO with wrap-bit pointers, registered fill level,
// threshold flags, synchronous flush and optional packet-gated output.
module axis_sync_fifo #(
    parameter int unsigned DATA_SIZE          = 16,
    parameter int unsigned DEPTH_LOG2         = 3,
    parameter int unsigned ALMOST_FULL_LEVEL  = 6,
    parameter int unsigned ALMOST_EMPTY_LEVEL = 2,
    parameter int unsigned PACKET_MODE        = 0
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  flush_i,
    input  logic [DATA_SIZE-1:0]  data_in_tdata,
    input  logic                  data_in_tlast,
    input  logic                  data_in_tvalid,
    output logic                  data_in_tready,
    output logic [DATA_SIZE-1:0]  data_out_tdata,
    output logic                  data_out_tlast,
    output logic                  data_out_tvalid,
    input  logic                  data_out_tready,
    output logic [DEPTH_LOG2:0]   level_o,
    output logic                  almost_full_o,
    output logic                  almost_empty_o
);

    localparam int unsigned PW    = DEPTH_LOG2 + 1;
    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam logic [PW-1:0] AF_LEVEL = PW'(ALMOST_FULL_LEVEL);
    localparam logic [PW-1:0] AE_LEVEL = PW'(ALMOST_EMPTY_LEVEL);

    logic [DATA_SIZE:0]    mem_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, rd_ptr_q, level_q, pkt_count_q;
    logic [DEPTH_LOG2-1:0] wr_addr, rd_addr;
    logic                  empty, full, pkt_ready;
    logic                  wr_en, rd_en, pkt_inc, pkt_dec;

    assign wr_addr = wr_ptr_q[DEPTH_LOG2-1:0];
    assign rd_addr = rd_ptr_q[DEPTH_LOG2-1:0];

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[DEPTH_LOG2] != rd_ptr_q[DEPTH_LOG2]) && (wr_addr == rd_addr);

    // Full override lets an oversized packet drain instead of deadlocking.
    assign pkt_ready = (PACKET_MODE == 0) || (pkt_count_q != '0) || full;

    assign data_in_tready  = !full && !flush_i;
    assign data_out_tvalid = !empty && !flush_i && pkt_ready;

    assign wr_en = data_in_tvalid && data_in_tready;
    assign rd_en = data_out_tvalid && data_out_tready;

    assign {data_out_tlast, data_out_tdata} = mem_q[rd_addr];

    assign pkt_inc = wr_en && data_in_tlast;
    assign pkt_dec = rd_en && data_out_tlast;

    always_ff @(posedge clk_i) begin
        if (wr_en) begin
            mem_q[wr_addr] <= {data_in_tlast, data_in_tdata};
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
            level_q <= level_q + PW'(wr_en) - PW'(rd_en);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pkt_count_q <= '0;
        end else if (flush_i) begin
            pkt_count_q <= '0;
        end else begin
            case ({pkt_inc, pkt_dec})
                2'b10:   pkt_count_q <= pkt_count_q + PW'(1);
                2'b01:   pkt_count_q <= pkt_count_q - PW'(1);
                default: pkt_count_q <= pkt_count_q;
            endcase
        end
    end

    assign level_o        = level_q;
    assign almost_full_o  = (level_q >= AF_LEVEL);
    assign almost_empty_o = (level_q <= AE_LEVEL);

endmodule

// File: doc/axis_sync_fifo.md
# axis_sync_fifo

Single-clock AXI-Stream FIFO with parametrised width and depth, full/empty detection with wrap-safe pointers, fill-level and threshold flags, synchronous flush, and an optional packet mode that holds output until a complete tlast-terminated packet is stored. It is the general-purpose buffering element between stream producers and consumers in the same clock domain. It replaces fixed 2-bit-counter buffering, which cannot tell full from empty.

## Interface
- DATA_SIZE, 16, tdata width in bits
- DEPTH_LOG2, 3, log2 of storage depth; DEPTH = 2**DEPTH_LOG2 words
- ALMOST_FULL_LEVEL, 6, almost_full_o threshold; legal range 1..DEPTH
- ALMOST_EMPTY_LEVEL, 2, almost_empty_o threshold; legal range 0..DEPTH-1
- PACKET_MODE, 0, 1 = output gated on stored complete packets

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous discard of all contents
- data_in_tdata  in  DATA_SIZE  write data
- data_in_tlast  in  1  end-of-packet marker, stored with the word
- data_in_tvalid  in  1  write request
- data_in_tready  out  1  FIFO can accept a word
- data_out_tdata  out  DATA_SIZE  head word (first-word-fall-through)
- data_out_tlast  out  1  tlast of head word
- data_out_tvalid  out  1  head word is valid
- data_out_tready  in  1  consumer accepts head word
- level_o  out  DEPTH_LOG2+1  words stored, 0..DEPTH
- almost_full_o  out  1  level_o >= ALMOST_FULL_LEVEL
- almost_empty_o  out  1  level_o <= ALMOST_EMPTY_LEVEL

## Operation
- Storage: DEPTH x (DATA_SIZE+1) array holding tdata and tlast. It is written on clk_i and has no reset.
- Pointers wr_ptr and rd_ptr are DEPTH_LOG2+1 bits. The low DEPTH_LOG2 bits address the array, and the MSB is a wrap bit.
- Empty: wr_ptr == rd_ptr.
- Full: MSBs differ and the low bits are equal.
- level_o = wr_ptr - rd_ptr, modulo 2**(DEPTH_LOG2+1). Registered.
- Write handshake: data_in_tvalid && data_in_tready. Stores the word at wr_ptr and increments wr_ptr; wrap-around is natural.
- Read handshake: data_out_tvalid && data_out_tready. Increments rd_ptr.
- data_in_tready = !full && !flush_i. It does not depend on data_out_tready, so there is no write-through when full.
- data_out_tdata/tlast = array[rd_ptr low bits], combinational read.
- PACKET_MODE=0: data_out_tvalid = !empty && !flush_i.
- PACKET_MODE=1: pkt_count (DEPTH_LOG2+1 bits) tracks stored tlast words.
  - +1 on a write of a tlast word; -1 on a read of a tlast word; unchanged when both happen in the same cycle.
  - data_out_tvalid = !empty && !flush_i && (pkt_count != 0 || full).
  - The full override releases a packet larger than DEPTH and prevents deadlock.
- Simultaneous write and read (not full, not empty): both pointers advance, and level_o is unchanged.
- Flush: while flush_i=1, no handshakes occur (tready=0, tvalid=0). At the next edge, wr_ptr, rd_ptr, level_o and pkt_count go to 0, with priority over everything else.
- Reset, asynchronous: pointers, level_o and pkt_count go to 0.
  - Output values during and after reset: data_out_tvalid=0, data_in_tready=1, level_o=0, almost_empty_o=1, almost_full_o=0.
  - data_out_tdata/tlast are don't-care while tvalid=0.
  - Handshakes while rst_ni=0 are discarded.
- Reset mid-operation: all contents are lost, and the FIFO behaves as freshly reset when rst_ni rises.

## Timing
- Write latency: a word accepted at edge N makes data_out_tvalid high in the cycle after edge N (one cycle), in non-packet mode.
  - In packet mode, the tlast word accepted at edge N releases the packet in the cycle after N.
- Read: the head word is presented combinationally. After a read at edge N, the next word is on data_out_tdata in the cycle after N.
- data_in_tready drops in the cycle after the edge that fills the FIFO. It rises in the cycle after the first read from full.
- level_o and the almost flags update in the cycle after the handshake edge.
- Sustained throughput: one word per cycle with simultaneous read and write.

## Test plan
- Fill/drain, DEPTH=8: write 8 words 0x0001..0x0008 with tready_out=0.
  - After the 8th edge: data_in_tready=0, level_o=8, almost_full_o=1.
  - Drain: output order is 0x0001..0x0008, then data_out_tvalid=0 and level_o=0.
- Wrap-around: 20 write/read cycles at level 3. Data order is preserved, and full is never falsely flagged after pointers wrap through 15→0.
- Simultaneous read and write when full: only the read occurs; level_o goes 8→7, and data_in_tready=1 in the next cycle.
- Flush with level 5: pulse flush_i for one cycle.
  - During the pulse: tready=0 and tvalid=0.
  - Next cycle: level_o=0, tvalid=0, almost_empty_o=1.
- Packet mode: write 3 words with tlast on the 3rd. data_out_tvalid stays 0 until the edge after the 3rd write. A 9-word packet with no tlast asserts tvalid once full.
- Async reset mid-stream at level 4: outputs take their reset values immediately. Post-reset writes read back correctly.
